// File: rtl/mux_test_pkg.sv
// Shared types and helpers for the 2-to-1 mux sweep checker.
// Holds the sweep FSM state type, vector width and the golden mux function.
package mux_test_pkg;

    localparam int unsigned VEC_W = 3;
    localparam logic [VEC_W-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StHold,
        StDone
    } state_e;

    // Golden 2-to-1 mux: x = vec[0], y = vec[1], s = vec[2].
    function automatic logic expected_m(input logic [VEC_W-1:0] vec);
        return vec[2] ? vec[1] : vec[0];
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter with a terminal-count flag, shared by the settle
// and hold phases of the sweep.
module hold_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    // Loading N-1 makes tc high on the Nth cycle after the load edge.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/mux_sweep_checker.sv
// Drives a 2-to-1 mux through all eight {s,y,x} vectors, samples its output
// after a settle window and keeps a saturating mismatch count.
module mux_sweep_checker
    import mux_test_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned ERR_W    = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic             continuous,
    input  logic             m_in,
    output logic             x,
    output logic             y,
    output logic             s,
    output logic             expected,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned CNT_W = cnt_width(max_u(SETTLE, TICK_DIV));
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(TICK_DIV - 1);

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic               expected_q;
    logic               busy_q;
    logic               tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               tmr_tc;

    hold_timer #(
        .WIDTH (CNT_W)
    ) u_hold_timer (
        .clock    (clock),
        .resetn   (resetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        err_d    = err_q;
        done_d   = done_q;
        pass_d   = pass_q;
        tmr_load = 1'b0;
        tmr_val  = SETTLE_LD;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d  = StSettle;
                    vec_d    = '0;
                    err_d    = '0;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            StSettle: begin
                if (tmr_tc) begin
                    // m_in is taken straight from the combinational mux here.
                    if ((m_in != expected_q) && (err_q != '1)) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    state_d  = StHold;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            StHold: begin
                if (tmr_tc) begin
                    if (vec_q != VEC_LAST) begin
                        vec_d    = vec_q + VEC_W'(1);
                        state_d  = StSettle;
                        tmr_load = 1'b1;
                    end else if (continuous) begin
                        vec_d    = '0;
                        state_d  = StSettle;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        pass_d  = (err_q == '0);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            vec_q      <= '0;
            err_q      <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            expected_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            err_q      <= err_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            expected_q <= expected_m(vec_d);
            busy_q     <= (state_d == StSettle) || (state_d == StHold);
        end
    end

    assign x         = vec_q[0];
    assign y         = vec_q[1];
    assign s         = vec_q[2];
    assign expected  = expected_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

endmodule
